// File: rtl/ssd_driver_pkg.sv
// Shared definitions for the seven-segment driver: converter FSM states,
// active-low segment patterns {g,f,e,d,c,b,a} and the digit encoder.
package ssd_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2
    } cvt_state_e;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Non-decimal nibbles cannot come out of the converter; show them blank.
    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] s;
        s = SEG_BLANK;
        case (d)
            4'd0: s = SEG_0;
            4'd1: s = SEG_1;
            4'd2: s = SEG_2;
            4'd3: s = SEG_3;
            4'd4: s = SEG_4;
            4'd5: s = SEG_5;
            4'd6: s = SEG_6;
            4'd7: s = SEG_7;
            4'd8: s = SEG_8;
            4'd9: s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ssd_driver_bcd_dd.sv
// Sequential double-dabble binary-to-BCD converter: one bit per cycle,
// result held on bcd and flagged by a one-cycle done while in LOAD.
module bcd_dd
    import ssd_driver_pkg::*;
#(
    parameter int WIDTH = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [15:0]      bcd
);

    cvt_state_e       state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [15:0]      bcd_q, bcd_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [15:0]      bcd_adj;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
        assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                                    bcd_q[4*gi +: 4] + 4'd3 : bcd_q[4*gi +: 4];
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    bin_d   = bin;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                {bcd_d, bin_d} = {bcd_adj[14:0], bin_q, 1'b0};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(WIDTH - 1)) state_d = ST_LOAD;
            end
            ST_LOAD:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_LOAD);
    assign bcd  = bcd_q;

endmodule

// File: rtl/ssd_driver.sv
// Four-digit multiplexed common-anode display driver: converts value_in to
// BCD whenever it changes and scans the digits at REFRESH_DIV cycles each.
module ssd_driver
    import ssd_driver_pkg::*;
#(
    parameter int WIDTH       = 13,
    parameter int REFRESH_DIV = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] value_in,
    input  logic             blank_lz,
    output logic [3:0]       anode,
    output logic [6:0]       seg,
    output logic             busy,
    output logic             upd
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [WIDTH-1:0] last_val_q, last_val_d;
    logic [15:0]      digits_q, digits_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       anode_q, anode_d;
    logic [6:0]       seg_q, seg_d;
    logic             cvt_start, cvt_busy, cvt_done;
    logic [15:0]      cvt_bcd;
    logic [6:0]       seg_cand [NUM_DIGITS];

    assign cvt_start = !cvt_busy && (value_in != last_val_q);

    bcd_dd #(.WIDTH(WIDTH)) u_bcd_dd (
        .clk   (clk),
        .rst   (rst),
        .start (cvt_start),
        .bin   (value_in),
        .busy  (cvt_busy),
        .done  (cvt_done),
        .bcd   (cvt_bcd)
    );

    // Segments are encoded from next-state digits and select so anode and
    // seg update on the same edge as the digit latch: no stale cycle.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_enc
        if (gi == 0) begin : g_ones
            assign seg_cand[gi] = seg_encode(digits_d[3:0]);
        end else begin : g_upper
            assign seg_cand[gi] = (blank_lz && (digits_d[15:4*gi] == '0)) ?
                                  SEG_BLANK : seg_encode(digits_d[4*gi +: 4]);
        end
    end

    always_comb begin
        last_val_d = cvt_start ? value_in : last_val_q;
        digits_d   = cvt_done ? cvt_bcd : digits_q;
        presc_d    = presc_q + 1'b1;
        sel_d      = sel_q;
        if (presc_q == PW'(REFRESH_DIV - 1)) begin
            presc_d = '0;
            sel_d   = sel_q + 2'd1;
        end
        anode_d = ~(4'b0001 << sel_d);
        seg_d   = seg_cand[sel_d];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_val_q <= '0;
            digits_q   <= '0;
            presc_q    <= '0;
            sel_q      <= '0;
            anode_q    <= 4'b1110;
            seg_q      <= SEG_0;
        end else begin
            last_val_q <= last_val_d;
            digits_q   <= digits_d;
            presc_q    <= presc_d;
            sel_q      <= sel_d;
            anode_q    <= anode_d;
            seg_q      <= seg_d;
        end
    end

    assign anode = anode_q;
    assign seg   = seg_q;
    assign busy  = cvt_busy;
    assign upd   = cvt_done;

endmodule

// File: tb/tb_ssd_driver.sv
// Directed bench for ssd_driver with a short refresh period; expected
// segment patterns come from a hand-written table.
module tb_ssd_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [12:0] value_in = '0;
    logic        blank_lz = 1'b0;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        busy;
    logic        upd;

    int checks = 0;
    int errors = 0;

    ssd_driver #(.WIDTH(13), .REFRESH_DIV(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .value_in (value_in),
        .blank_lz (blank_lz),
        .anode    (anode),
        .seg      (seg),
        .busy     (busy),
        .upd      (upd)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input logic [15:0] dig, input int idx, input logic bl);
        logic [15:0] upper;
        upper = dig >> (4 * idx);
        if (idx > 0 && bl && upper == 16'd0) return 7'b1111111;
        return enc(upper[3:0]);
    endfunction

    // Check seg against whichever digit is currently selected.
    task automatic check_now(input string tag, input logic [15:0] dig);
        int idx;
        case (anode)
            4'b1110: idx = 0;
            4'b1101: idx = 1;
            4'b1011: idx = 2;
            4'b0111: idx = 3;
            default: idx = -1;
        endcase
        chk({tag, "_anode_onehot"}, (idx >= 0), 1);
        if (idx >= 0) chk({tag, "_seg"}, seg, exp_seg(dig, idx, blank_lz));
    endtask

    task automatic check_scan(input string tag, input logic [15:0] dig);
        for (int k = 0; k < 4; k++) begin
            logic [3:0] want;
            bit found;
            want  = ~(4'b0001 << k);
            found = 0;
            for (int n = 0; n < 20 && !found; n++) begin
                if (anode === want) found = 1;
                else step();
            end
            chk($sformatf("%s_reach_anode%0d", tag, k), found, 1);
            if (found)
                chk($sformatf("%s_seg_digit%0d", tag, k), seg, exp_seg(dig, k, blank_lz));
        end
    endtask

    task automatic wait_upd(input string tag, output int n);
        bit seen;
        seen = 0;
        n = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            n++;
            if (upd === 1'b1) seen = 1;
        end
        chk({tag, "_upd_seen"}, seen, 1);
    endtask

    task automatic measure_hold(input string tag);
        logic [3:0] a;
        int n;
        bit changed;
        a = anode;
        changed = 0;
        for (int i = 0; i < 10 && !changed; i++) begin
            step();
            if (anode !== a) changed = 1;
        end
        a = anode;
        n = 0;
        changed = 0;
        for (int i = 0; i < 10 && !changed; i++) begin
            step();
            n++;
            if (anode !== a) changed = 1;
        end
        chk({tag, "_hold_cycles"}, n, 4);
    endtask

    initial begin
        int n, busy_n, upd_n, upd_at;

        // Reset held for three cycles
        #1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_anode", anode, 4'b1110);
            chk("rst_seg", seg, 7'b1000000);
            chk("rst_busy", busy, 1'b0);
            chk("rst_upd", upd, 1'b0);
        end
        rst = 1'b0;
        step();
        chk("idle_busy", busy, 1'b0);

        // Conversion latency with 1234
        value_in = 13'd1234;
        busy_n = 0; upd_n = 0; upd_at = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (busy === 1'b1) busy_n++;
            if (upd === 1'b1) begin
                upd_n++;
                upd_at = i;
            end
        end
        chk("lat_busy_cycles", busy_n, 14);
        chk("lat_upd_count", upd_n, 1);
        chk("lat_upd_pos", upd_at, 14);
        check_scan("v1234", 16'h1234);
        measure_hold("v1234_a");
        measure_hold("v1234_b");

        // Maximum value
        value_in = 13'd8191;
        wait_upd("v8191", n);
        step();
        check_now("v8191_load", 16'h8191);
        check_scan("v8191", 16'h8191);

        // Leading-zero blanking
        value_in = 13'd9;
        blank_lz = 1'b1;
        wait_upd("v9", n);
        step();
        check_scan("v9_blank", 16'h0009);
        blank_lz = 1'b0;
        step();
        check_scan("v9_noblank", 16'h0009);

        // Change during conversion: 500 then 42
        value_in = 13'd500;
        step();
        chk("chg_busy_start", busy, 1'b1);
        repeat (3) step();
        value_in = 13'd42;
        wait_upd("chg_first", n);
        step();
        check_now("chg_500", 16'h0500);
        n = 1;
        for (int i = 0; i < 40 && upd !== 1'b1; i++) begin
            step();
            n++;
        end
        chk("chg_upd_spacing", n, 15);
        step();
        chk("chg_busy_after", busy, 1'b0);
        check_now("chg_42", 16'h0042);
        check_scan("chg_42_scan", 16'h0042);

        // Reset mid-conversion with 777
        value_in = 13'd777;
        step();
        repeat (6) step();
        chk("rmid_busy7", busy, 1'b1);
        rst = 1'b1;
        step();
        chk("rmid_busy", busy, 1'b0);
        chk("rmid_upd", upd, 1'b0);
        chk("rmid_anode", anode, 4'b1110);
        chk("rmid_seg", seg, 7'b1000000);
        rst = 1'b0;
        step();
        chk("rmid_restart_busy", busy, 1'b1);
        wait_upd("rmid", n);
        step();
        check_scan("v777", 16'h0777);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
